// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-channel TDM receive path.
package tdm_pkg;

  localparam int TDM_CHANNELS = 16;
  localparam int TDM_SLOT_W   = 4;

  // Frame-alignment lock state: HUNT waits for frame_sync, RUN follows slots.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  typedef logic [TDM_SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_demux_1x16.sv
// Combinational 1-to-16 one-hot decoder; all zeros when enable is low.
module demux_1x16
  import tdm_pkg::*;
(
  input  logic                    en,
  input  slot_t                   sel,
  output logic [TDM_CHANNELS-1:0] out
);

  // One-hot decode of sel, gated by en.
  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_16.sv
// tdm_demux_16: de-serialises a 16-slot TDM bit stream into 16-bit frames.
// Optional macro TDM_DEMUX_LOSS_DETECT_EN: two consecutive slot-0 bits without
// frame_sync while locked drop the block back to HUNT.
//
// Handshake: din/frame_sync are consumed only in cycles where din_valid is
// high; din_valid low is a stall that holds every register, and the pulse
// outputs frame_valid/sync_err are low during a stall.
module tdm_demux_16
  import tdm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    frame_sync,
  output logic [TDM_CHANNELS-1:0] chan_out,
  output logic                    frame_valid,
  output logic [TDM_CHANNELS-1:0] chan_strobe,
  output logic [TDM_SLOT_W-1:0]   slot,
  output logic                    locked,
  output logic                    sync_err
);

  tdm_state_t              state, state_n;
  slot_t                   slot_q, slot_n;
  logic [TDM_CHANNELS-1:0] asm_q, asm_n;
  logic [TDM_CHANNELS-1:0] chan_n;
  logic                    fv_n, se_n;
  logic                    sync_hit, accept, drop, wr_en;
  slot_t                   sel;
  logic [TDM_CHANNELS-1:0] strobe;

`ifdef TDM_DEMUX_LOSS_DETECT_EN
  logic [1:0] miss_q, miss_n;
`endif

  assign sync_hit = din_valid & frame_sync;
  assign accept   = din_valid & ((state == RUN) | frame_sync);
  // A (re)sync bit always lands in slot 0 regardless of the slot counter.
  assign sel      = sync_hit ? slot_t'(0) : slot_q;

`ifdef TDM_DEMUX_LOSS_DETECT_EN
  // Second consecutive slot-0 without frame_sync: the bit is thrown away.
  assign drop = din_valid & (state == RUN) & ~frame_sync &
                (slot_q == slot_t'(0)) & (miss_q != 2'd0);
`else
  assign drop = 1'b0;
`endif

  assign wr_en = accept & ~drop;

  demux_1x16 u_dec (
    .en  (wr_en),
    .sel (sel),
    .out (strobe)
  );

  assign chan_strobe = strobe;
  assign slot        = slot_q;
  assign locked      = (state == RUN);

  // Next-state, assembly and frame-publication logic.
  always_comb begin
    state_n = state;
    slot_n  = slot_q;
    asm_n   = asm_q;
    chan_n  = chan_out;
    fv_n    = 1'b0;
    se_n    = 1'b0;
`ifdef TDM_DEMUX_LOSS_DETECT_EN
    miss_n  = miss_q;
`endif
    if (drop) begin
      state_n = HUNT;
      slot_n  = '0;
      asm_n   = '0;
      se_n    = 1'b1;
`ifdef TDM_DEMUX_LOSS_DETECT_EN
      miss_n  = 2'd0;
`endif
    end else if (sync_hit) begin
      // Any partial frame is discarded; this bit starts a new frame.
      state_n = RUN;
      slot_n  = slot_t'(1);
      asm_n   = {{(TDM_CHANNELS-1){1'b0}}, din};
      se_n    = (state == RUN) && (slot_q != slot_t'(0));
`ifdef TDM_DEMUX_LOSS_DETECT_EN
      miss_n  = 2'd0;
`endif
    end else if (wr_en) begin
      asm_n = (asm_q & ~strobe) | (strobe & {TDM_CHANNELS{din}});
`ifdef TDM_DEMUX_LOSS_DETECT_EN
      if (slot_q == slot_t'(0)) miss_n = miss_q + 2'd1;
`endif
      if (slot_q == slot_t'(TDM_CHANNELS-1)) begin
        chan_n = {din, asm_q[TDM_CHANNELS-2:0]};
        fv_n   = 1'b1;
        slot_n = '0;
      end else begin
        slot_n = slot_q + slot_t'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot_q      <= '0;
      asm_q       <= '0;
      chan_out    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_LOSS_DETECT_EN
      miss_q      <= 2'd0;
`endif
    end else begin
      state       <= state_n;
      slot_q      <= slot_n;
      asm_q       <= asm_n;
      chan_out    <= chan_n;
      frame_valid <= fv_n;
      sync_err    <= se_n;
`ifdef TDM_DEMUX_LOSS_DETECT_EN
      miss_q      <= miss_n;
`endif
    end
  end

endmodule
